char_xform_stream: RTL and testbench
====================================

# char_xform_stream

Streaming, parametrised successor to the three-character combinational code shaper. It accepts words of `N_CHARS` ASCII bytes over a valid/ready handshake and applies a per-word mode: pass-through, upper-case, lower-case or Caesar rotation. Results are registered into a `DEPTH`-entry output FIFO, so upstream text sources and downstream consumers can stall independently. It sits between the character-code source and any display or encoder stage.

## Interface
Parameters:
- `N_CHARS`, 3: bytes per word; byte k occupies bits [8k+7:8k].
- `DEPTH`, 4: output FIFO entries; must be a power of two, ≥2.
- `CNT_W`, 16: width of the accepted-word counter.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset; synchronous and active-high.
- `i_valid`  in  1  input word present.
- `o_ready`  out  1  block can accept a word this cycle.
- `i_code`  in  8*N_CHARS  input ASCII word.
- `i_mode`  in  2  00 pass, 01 upper, 10 lower, 11 rotate; sampled with the word.
- `i_shift`  in  5  rotate amount, used mod 26; sampled with the word.
- `o_valid`  out  1  output word present (FIFO not empty).
- `i_ready`  in  1  downstream accepts the output word.
- `o_code`  out  8*N_CHARS  head-of-FIFO transformed word.
- `o_letters`  out  $clog2(N_CHARS+1)  number of letter bytes in `o_code`.
- `o_words`  out  CNT_W  words accepted since reset; saturates at all-ones.

## Operation
- Accept when `i_valid && o_ready`. Deliver when `o_valid && i_ready`.
- Each byte is transformed independently:
  - Mode 00: unchanged.
  - Mode 01: 0x61–0x7A minus 0x20.
  - Mode 10: 0x41–0x5A plus 0x20.
  - Mode 11: letters rotate within their own case by `i_shift mod 26`, wrapping z→a and Z→A. Shifts 26–31 map to 0–5.
  - Non-letters, including 0x00, space and bytes ≥ 0x80, pass unchanged in all modes.
- `o_letters` counts bytes in the result that lie in A–Z or a–z. It is stored in the FIFO alongside the word.
- FIFO is show-ahead: `o_code` and `o_letters` are valid whenever `o_valid` is high, and hold stable while `o_valid && !i_ready`.
- `o_ready` = FIFO not full. No pass-through when full: a same-cycle pop does not enable a push.
- When the FIFO is neither empty nor full, a simultaneous push and pop is allowed and the occupancy is unchanged.
- `o_words` increments on every accept and stops at 2^CNT_W−1.

## Timing
- Reset values: `o_valid`=0, `o_ready`=1, `o_code`=0, `o_letters`=0, `o_words`=0. FIFO pointers and occupancy are 0.
- Latency is 1 cycle. A word accepted at edge N is presented with `o_valid`=1 after edge N, provided the FIFO was empty or drains ahead of it.
- Throughput is one word per cycle with `i_ready` held high.
- `o_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.
- `i_rst` asserted mid-stream flushes all entries on that edge; in-flight words are discarded. The handshake at a reset edge is ignored.
- Pointers wrap modulo `DEPTH`. Full/empty are derived from an occupancy counter of width $clog2(DEPTH)+1.

## Structure
- Package `char_xform_pkg` holds:
  - mode constants `MODE_PASS`, `MODE_UPPER`, `MODE_LOWER`, `MODE_ROT`;
  - ASCII bounds `ASC_A`, `ASC_Z`, `ASC_LA`, `ASC_LZ`, and `CASE_DELTA` = 0x20;
  - the alphabet length 26.
- Sub-module `char_xform_lane`: purely combinational single-byte transform with an is-letter output. It is instantiated `N_CHARS` times via generate.
- The top level holds the handshake, FIFO storage, counters and the letter-count adder.

## Test plan
- Reset with no traffic → `o_valid`=0, `o_ready`=1, `o_words`=0. Assert `i_rst` again after traffic → the same values on the next cycle.
- Mode 01, `i_code`=0x7A6167 ("zag") → `o_code`=0x5A4147 and `o_letters`=3 one cycle later. Mode 10 on 0x434241 → 0x636261.
- Mode 11, shift 3, 0x78797A ("xyz") → 0x616263. The same word with shift 29 → 0x616263. Shift 1 on 0x206869 → 0x20696A with `o_letters`=2.
- Mode 11, shift 5 on 0x000042 → 0x000047 with `o_letters`=1; the NUL bytes are untouched.
- Backpressure:
  - With `i_ready`=0, stream 5 words → 4 accepted, `o_ready`=0, `o_words`=4.
  - Raise `i_ready` → the 4 words emerge in order, then the 5th is accepted and delivered.
- Continuous push/pop with `i_ready`=1 over 100 random words → output order and values match a software model, and `o_words`=100.

Source files
------------

// File: rtl/char_xform_stream_pkg.sv
// Shared constants for the character transform stream: mode encodings,
// ASCII letter bounds and a letter-classification helper.
package char_xform_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_UPPER = 2'b01,
        MODE_LOWER = 2'b10,
        MODE_ROT   = 2'b11
    } mode_e;

    localparam logic [7:0] ASC_A      = 8'h41;
    localparam logic [7:0] ASC_Z      = 8'h5A;
    localparam logic [7:0] ASC_LA     = 8'h61;
    localparam logic [7:0] ASC_LZ     = 8'h7A;
    localparam logic [7:0] CASE_DELTA = 8'h20;
    localparam int         ALPHA_LEN  = 26;

    function automatic logic is_alpha(input logic [7:0] c);
        return ((c >= ASC_A) && (c <= ASC_Z)) || ((c >= ASC_LA) && (c <= ASC_LZ));
    endfunction

endpackage

// File: rtl/char_xform_stream_if.sv
// Handshake bundle for char_xform_stream: upstream word port and
// downstream FIFO head port, plus the accepted-word counter.
interface char_xform_stream_if #(
    parameter int N_CHARS = 3,
    parameter int CNT_W   = 16
);
    localparam int LW = $clog2(N_CHARS + 1);

    logic                   i_valid;
    logic                   o_ready;
    logic [8*N_CHARS-1:0]   i_code;
    logic [1:0]             i_mode;
    logic [4:0]             i_shift;
    logic                   o_valid;
    logic                   i_ready;
    logic [8*N_CHARS-1:0]   o_code;
    logic [LW-1:0]          o_letters;
    logic [CNT_W-1:0]       o_words;

    modport slave (
        input  i_valid, i_code, i_mode, i_shift, i_ready,
        output o_ready, o_valid, o_code, o_letters, o_words
    );

    modport master (
        output i_valid, i_code, i_mode, i_shift, i_ready,
        input  o_ready, o_valid, o_code, o_letters, o_words
    );

endinterface

// File: rtl/char_xform_stream_lane.sv
// Combinational single-byte transform (pass / upper / lower / Caesar rotate)
// with a flag telling whether the resulting byte is a letter.
module char_xform_lane
    import char_xform_pkg::*;
(
    input  logic [7:0] i_char,
    input  logic [1:0] i_mode,
    input  logic [4:0] i_shift,
    output logic [7:0] o_char,
    output logic       o_is_letter
);

    logic       is_up;
    logic       is_lo;
    logic [4:0] shift_mod;
    logic [7:0] base;
    logic [7:0] rot_sum;

    always_comb begin
        is_up     = (i_char >= ASC_A)  && (i_char <= ASC_Z);
        is_lo     = (i_char >= ASC_LA) && (i_char <= ASC_LZ);
        // 5-bit shift never exceeds 31, so one conditional subtract is a full mod 26
        shift_mod = (i_shift >= 5'(ALPHA_LEN)) ? (i_shift - 5'(ALPHA_LEN)) : i_shift;
        base      = is_up ? ASC_A : ASC_LA;
        rot_sum   = (i_char - base) + {3'b000, shift_mod};
        if (rot_sum >= 8'(ALPHA_LEN)) begin
            rot_sum = rot_sum - 8'(ALPHA_LEN);
        end

        o_char = i_char;
        case (i_mode)
            MODE_UPPER: if (is_lo) o_char = i_char - CASE_DELTA;
            MODE_LOWER: if (is_up) o_char = i_char + CASE_DELTA;
            MODE_ROT:   if (is_up || is_lo) o_char = base + rot_sum;
            default:    o_char = i_char;
        endcase

        o_is_letter = is_alpha(o_char);
    end

endmodule

// File: rtl/char_xform_stream.sv
// Streaming character transform: per-word lane transforms feeding a
// show-ahead output FIFO, with letter counting and a saturating word counter.
module char_xform_stream
    import char_xform_pkg::*;
#(
    parameter int N_CHARS = 3,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    char_xform_stream_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(N_CHARS + 1);
    localparam int W  = 8 * N_CHARS;

    logic [W-1:0]       xf_code;
    logic [N_CHARS-1:0] lane_letter;
    logic [LW-1:0]      letter_cnt;

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q,  count_d;
    logic [CNT_W-1:0]   words_q,  words_d;

    logic [W-1:0]       code_mem_q [DEPTH];
    logic [LW-1:0]      let_mem_q  [DEPTH];

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    generate
        for (genvar gi = 0; gi < N_CHARS; gi++) begin : g_lane
            char_xform_lane u_lane (
                .i_char      (bus.i_code[8*gi +: 8]),
                .i_mode      (bus.i_mode),
                .i_shift     (bus.i_shift),
                .o_char      (xf_code[8*gi +: 8]),
                .o_is_letter (lane_letter[gi])
            );
        end
    endgenerate

    always_comb begin
        letter_cnt = '0;
        for (int k = 0; k < N_CHARS; k++) begin
            letter_cnt = letter_cnt + LW'(lane_letter[k]);
        end
    end

    // Push depends only on full: a pop in the same cycle never frees a slot early
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        push  = bus.i_valid && !full;
        pop   = !empty && bus.i_ready;

        wr_ptr_d = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + 1'b1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        words_d = words_q;
        if (push && (words_q != '1)) begin
            words_d = words_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            words_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            words_q  <= words_d;
        end
    end

    // Storage is not reset; the occupancy counter alone decides what is visible
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            code_mem_q[wr_ptr_q] <= xf_code;
            let_mem_q[wr_ptr_q]  <= letter_cnt;
        end
    end

    always_comb begin
        bus.o_valid   = !empty;
        bus.o_ready   = !full;
        bus.o_code    = empty ? '0 : code_mem_q[rd_ptr_q];
        bus.o_letters = empty ? '0 : let_mem_q[rd_ptr_q];
        bus.o_words   = words_q;
    end

endmodule

// File: tb/tb_char_xform_stream.sv
// Scoreboard bench for char_xform_stream: directed vectors, backpressure
// against a full FIFO, and a random streaming run.
module tb_char_xform_stream;

    localparam int N_CHARS = 3;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 16;
    localparam int W       = 8 * N_CHARS;
    localparam int LW      = $clog2(N_CHARS + 1);

    typedef struct {
        logic [W-1:0]  code;
        logic [LW-1:0] letters;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    char_xform_stream_if #(.N_CHARS(N_CHARS), .CNT_W(CNT_W)) bus ();

    char_xform_stream #(.N_CHARS(N_CHARS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [7:0] c, input logic [1:0] m, input int sh);
        bit up;
        bit lo;
        up = (c >= 8'h41) && (c <= 8'h5A);
        lo = (c >= 8'h61) && (c <= 8'h7A);
        case (m)
            2'd1: return lo ? c - 8'h20 : c;
            2'd2: return up ? c + 8'h20 : c;
            2'd3: begin
                if (up) return 8'(65 + ((int'(c) - 65 + (sh % 26)) % 26));
                if (lo) return 8'(97 + ((int'(c) - 97 + (sh % 26)) % 26));
                return c;
            end
            default: return c;
        endcase
    endfunction

    function automatic exp_t model_word(input logic [W-1:0] code, input logic [1:0] m, input logic [4:0] sh);
        exp_t e;
        logic [7:0] b;
        e.letters = '0;
        for (int k = 0; k < N_CHARS; k++) begin
            b = model_byte(code[8*k +: 8], m, int'(sh));
            e.code[8*k +: 8] = b;
            if (((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A))) e.letters++;
        end
        return e;
    endfunction

    // Observe handshakes on the falling edge; they take effect at the next rising edge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.o_valid && bus.i_ready) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    $display("deliver code=%06h letters=%0d", bus.o_code, bus.o_letters);
                    check_val("o_code", 64'(bus.o_code), 64'(e.code));
                    check_val("o_letters", 64'(bus.o_letters), 64'(e.letters));
                end
            end
            if (bus.i_valid && bus.o_ready) begin
                sb.push_back(model_word(bus.i_code, bus.i_mode, bus.i_shift));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rst_o_valid", 64'(bus.o_valid), 64'd0);
        check_val("rst_o_ready", 64'(bus.o_ready), 64'd1);
        check_val("rst_o_words", 64'(bus.o_words), 64'd0);
        check_val("rst_o_code", 64'(bus.o_code), 64'd0);
        check_val("rst_o_letters", 64'(bus.o_letters), 64'd0);
    endtask

    task automatic send(input logic [W-1:0] code, input logic [1:0] m, input logic [4:0] sh);
        int n;
        bus.i_valid = 1'b1;
        bus.i_code  = code;
        bus.i_mode  = m;
        bus.i_shift = sh;
        n = 0;
        while (!bus.o_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.o_ready) check_val("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic send_expect(input string tag, input logic [W-1:0] code, input logic [1:0] m,
                               input logic [4:0] sh, input logic [W-1:0] exp_code, input int exp_let);
        send(code, m, sh);
        check_val({tag, "_valid"}, 64'(bus.o_valid), 64'd1);
        check_val({tag, "_code"}, 64'(bus.o_code), 64'(exp_code));
        check_val({tag, "_letters"}, 64'(bus.o_letters), 64'(exp_let));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.o_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("drain_done", 64'(n < 200), 64'd1);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_code  = '0;
        bus.i_mode  = 2'b00;
        bus.i_shift = '0;
        bus.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        send_expect("upper_zag", 24'h7A6167, 2'b01, 5'd0, 24'h5A4147, 3);
        send_expect("lower_cba", 24'h434241, 2'b10, 5'd0, 24'h636261, 3);
        send_expect("rot3_xyz", 24'h78797A, 2'b11, 5'd3, 24'h616263, 3);
        send_expect("rot29_xyz", 24'h78797A, 2'b11, 5'd29, 24'h616263, 3);
        send_expect("rot1_sp", 24'h206869, 2'b11, 5'd1, 24'h20696A, 2);
        send_expect("rot5_nul", 24'h000042, 2'b11, 5'd5, 24'h000047, 1);
        send_expect("pass_hi", 24'hE17A20, 2'b00, 5'd0, 24'hE17A20, 1);
        send_expect("upper_hi", 24'hFF615A, 2'b01, 5'd0, 24'hFF415A, 2);
        wait_drain();
        check_val("dir_words", 64'(bus.o_words), 64'd8);

        do_reset();

        // Backpressure: fill the FIFO, then hold a fifth word against it
        bus.i_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) send(24'h616263 + 24'(k), 2'b01, 5'd0);
        bus.i_valid = 1'b1;
        bus.i_code  = 24'h5A5A20;
        bus.i_mode  = 2'b11;
        bus.i_shift = 5'd1;
        repeat (2) begin @(posedge clk); #1; end
        check_val("bp_o_ready", 64'(bus.o_ready), 64'd0);
        check_val("bp_o_words", 64'(bus.o_words), 64'd4);
        check_val("bp_o_valid", 64'(bus.o_valid), 64'd1);
        check_val("bp_hold_head", 64'(bus.o_code), 64'h414243);
        bus.i_ready = 1'b1;
        n = 0;
        while (!bus.o_ready && n < 20) begin @(posedge clk); #1; n++; end
        check_val("bp_ready_rise", 64'(bus.o_ready), 64'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        wait_drain();
        check_val("bp_words5", 64'(bus.o_words), 64'd5);

        do_reset();

        for (int k = 0; k < 100; k++) begin
            send(24'($urandom), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
        end
        wait_drain();
        check_val("rand_words", 64'(bus.o_words), 64'd100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
